univ_shift_reg_n: RTL and testbench

- Parametrised universal shift register. Successor to the team's 8-bit load/shift-left/shift-right register.
- Adds the following over that register:
  - configurable width
  - rotate modes
  - an arithmetic shift-right mode
  - a multi-cycle burst mode that applies a shift or rotate AMT times, with BUSY/DONE status
- Used in datapath and serial-link logic wherever a register needs load, serial shift or N-step shift under FSM control.

---
 rtl/univ_shift_reg_n_if.sv | 28 ++
 rtl/univ_shift_reg_n.sv | 101 ++++++++++
 tb/tb_univ_shift_reg_n.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/univ_shift_reg_n_if.sv
// Control/data bundle for univ_shift_reg_n: operation select, burst request,
// serial and parallel inputs, register contents and burst status.
interface univ_shift_reg_n_if #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
);
  logic [2:0]       S;
  logic             START;
  logic [CNTW-1:0]  AMT;
  logic             SDL;
  logic             SDR;
  logic [WIDTH-1:0] D;
  logic [WIDTH-1:0] Q;
  logic             SOL;
  logic             SOR;
  logic             BUSY;
  logic             DONE;

  modport master (
    output S, START, AMT, SDL, SDR, D,
    input  Q, SOL, SOR, BUSY, DONE
  );

  modport slave (
    input  S, START, AMT, SDL, SDR, D,
    output Q, SOL, SOR, BUSY, DONE
  );
endinterface

// File: rtl/univ_shift_reg_n.sv
// Parametrised universal shift register: hold/shift/load/rotate/ASR per cycle,
// plus an N-step burst of any shift or rotate with BUSY/DONE status.
module univ_shift_reg_n #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input logic              CLK,
  input logic              CLR,
  univ_shift_reg_n_if.slave bus
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;

  typedef enum logic {IDLE, RUN} state_t;

  state_t           state;
  logic [WIDTH-1:0] q;
  logic [CNTW-1:0]  cnt;
  logic [2:0]       mode;
  logic             busy;
  logic             done;

  // One step of operation op applied to the current contents.
  function automatic logic [WIDTH-1:0] step(
    input logic [2:0]       op,
    input logic [WIDTH-1:0] cur,
    input logic             sdl,
    input logic             sdr,
    input logic [WIDTH-1:0] d
  );
    logic [WIDTH-1:0] nxt;
    nxt = cur;
    case (op)
      OP_SHR:  nxt = {sdr, cur[WIDTH-1:1]};
      OP_SHL:  nxt = {cur[WIDTH-2:0], sdl};
      OP_LOAD: nxt = d;
      OP_ROR:  nxt = {cur[0], cur[WIDTH-1:1]};
      OP_ROL:  nxt = {cur[WIDTH-2:0], cur[WIDTH-1]};
      OP_ASR:  nxt = {cur[WIDTH-1], cur[WIDTH-1:1]};
      default: nxt = cur;
    endcase
    return nxt;
  endfunction

  // Only shifts and rotates can be repeated as a burst.
  function automatic logic is_burst_op(input logic [2:0] op);
    return (op != OP_HOLD) && (op != OP_LOAD) && (op != 3'b111);
  endfunction

  always_ff @(posedge CLK) begin
    if (CLR) begin
      state <= IDLE;
      q     <= '0;
      cnt   <= '0;
      mode  <= OP_HOLD;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.START && is_burst_op(bus.S)) begin
            if (bus.AMT == '0) begin
              done <= 1'b1;
            end else begin
              mode  <= bus.S;
              cnt   <= bus.AMT;
              busy  <= 1'b1;
              state <= RUN;
            end
          end else begin
            q <= step(bus.S, q, bus.SDL, bus.SDR, bus.D);
          end
        end
        RUN: begin
          q   <= step(mode, q, bus.SDL, bus.SDR, bus.D);
          cnt <= cnt - CNTW'(1);
          if (cnt == CNTW'(1)) begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.Q    = q;
  assign bus.SOL  = q[WIDTH-1];
  assign bus.SOR  = q[0];
  assign bus.BUSY = busy;
  assign bus.DONE = done;

endmodule

// File: tb/tb_univ_shift_reg_n.sv
// Randomised and directed bench for univ_shift_reg_n against an arithmetic
// reference model of the register, burst counter and status flags.
module tb_univ_shift_reg_n;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNTW  = 4;
  localparam int          MASK  = (1 << WIDTH) - 1;
  localparam int          MSB   = 1 << (WIDTH - 1);

  logic CLK;
  logic CLR;

  univ_shift_reg_n_if #(.WIDTH(WIDTH), .CNTW(CNTW)) bus ();

  univ_shift_reg_n #(.WIDTH(WIDTH), .CNTW(CNTW)) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model state
  int  mq;
  int  mrem;
  int  mmode;
  bit  mbusy;
  bit  mdone;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic int apply(input int op, input int cur, input int sdl, input int sdr, input int d);
    case (op)
      1: return (cur >> 1) | (sdr * MSB);
      2: return ((cur * 2) + sdl) & MASK;
      3: return d & MASK;
      4: return (cur >> 1) | ((cur % 2) * MSB);
      5: return ((cur * 2) & MASK) | (cur / MSB);
      6: return (cur >> 1) | (cur & MSB);
      default: return cur;
    endcase
  endfunction

  function automatic bit burstable(input int op);
    return op == 1 || op == 2 || op == 4 || op == 5 || op == 6;
  endfunction

  task automatic model_step();
    int op;
    op = int'(bus.S);
    if (CLR) begin
      mq = 0; mrem = 0; mbusy = 0; mdone = 0; mmode = 0;
    end else begin
      mdone = 0;
      if (mbusy) begin
        mq = apply(mmode, mq, int'(bus.SDL), int'(bus.SDR), int'(bus.D));
        mrem--;
        if (mrem == 0) begin
          mbusy = 0;
          mdone = 1;
        end
      end else if (bus.START && burstable(op)) begin
        if (bus.AMT == '0) mdone = 1;
        else begin
          mmode = op;
          mrem  = int'(bus.AMT);
          mbusy = 1;
        end
      end else begin
        mq = apply(op, mq, int'(bus.SDL), int'(bus.SDR), int'(bus.D));
      end
    end
  endtask

  // Advance one edge, then compare every output against the model.
  task automatic tick();
    model_step();
    @(posedge CLK);
    #1;
    check("q",    32'(bus.Q),    32'(mq));
    check("busy", 32'(bus.BUSY), 32'(mbusy));
    check("done", 32'(bus.DONE), 32'(mdone));
    check("sol",  32'(bus.SOL),  32'((mq / MSB) % 2));
    check("sor",  32'(bus.SOR),  32'(mq % 2));
  endtask

  task automatic drive(input logic [2:0] s, input logic start, input logic [CNTW-1:0] amt,
                       input logic sdl, input logic sdr, input logic [WIDTH-1:0] d);
    bus.S = s; bus.START = start; bus.AMT = amt;
    bus.SDL = sdl; bus.SDR = sdr; bus.D = d;
  endtask

  task automatic op1(input logic [2:0] s, input logic sdl, input logic sdr, input logic [WIDTH-1:0] d);
    drive(s, 1'b0, '0, sdl, sdr, d);
    tick();
  endtask

  initial begin
    int busy_cycles;
    mq = 0; mrem = 0; mmode = 0; mbusy = 0; mdone = 0;
    CLR = 1'b1;
    drive(3'b011, 1'b0, '0, 1'b0, 1'b0, 8'h5A);
    tick();
    tick();
    CLR = 1'b0;

    // Reset overrides a simultaneous load
    op1(3'b011, 1'b1, 1'b1, 8'h3C);
    CLR = 1'b1;
    op1(3'b011, 1'b0, 1'b0, 8'hA5);
    check("rst_q", 32'(bus.Q), 32'h00);
    check("rst_busy", 32'(bus.BUSY), 32'h0);
    CLR = 1'b0;

    // Single steps
    op1(3'b011, 1'b0, 1'b0, 8'h81); check("load", 32'(bus.Q), 32'h81);
    op1(3'b010, 1'b1, 1'b0, 8'h00); check("shl",  32'(bus.Q), 32'h03);
    op1(3'b001, 1'b0, 1'b1, 8'h00); check("shr",  32'(bus.Q), 32'h81);
    op1(3'b110, 1'b0, 1'b0, 8'h00); check("asr",  32'(bus.Q), 32'hC0);
    op1(3'b100, 1'b0, 1'b0, 8'h00); check("ror",  32'(bus.Q), 32'h60);
    op1(3'b111, 1'b1, 1'b1, 8'hFF); check("rsvd", 32'(bus.Q), 32'h60);

    // Burst ROL x3 with garbage on ignored inputs
    op1(3'b011, 1'b0, 1'b0, 8'h81);
    drive(3'b101, 1'b1, 4'd3, 1'b0, 1'b0, 8'h00);
    tick();
    check("rol_accept_q", 32'(bus.Q), 32'h81);
    check("rol_accept_busy", 32'(bus.BUSY), 32'h1);
    drive(3'b011, 1'b1, 4'd9, 1'b1, 1'b1, 8'hEE); tick();
    check("rol_s1", 32'(bus.Q), 32'h03);
    drive(3'b001, 1'b1, 4'd0, 1'b0, 1'b1, 8'h11); tick();
    check("rol_s2", 32'(bus.Q), 32'h06);
    drive(3'b000, 1'b0, 4'd5, 1'b1, 1'b0, 8'h22); tick();
    check("rol_s3", 32'(bus.Q), 32'h0C);
    check("rol_done", 32'(bus.DONE), 32'h1);
    check("rol_busy_end", 32'(bus.BUSY), 32'h0);
    op1(3'b000, 1'b0, 1'b0, 8'h00);
    check("rol_done_clr", 32'(bus.DONE), 32'h0);

    // Burst ASR x2
    op1(3'b011, 1'b0, 1'b0, 8'h80);
    drive(3'b110, 1'b1, 4'd2, 1'b0, 1'b0, 8'h00); tick();
    drive(3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00); tick(); tick();
    check("asr_burst", 32'(bus.Q), 32'hE0);

    // Burst SHR x10 exceeds width
    op1(3'b011, 1'b0, 1'b0, 8'hFF);
    drive(3'b001, 1'b1, 4'd10, 1'b0, 1'b0, 8'h00);
    busy_cycles = 0;
    for (int i = 0; i < 20 && !bus.DONE; i++) begin
      tick();
      bus.START = 1'b0;
      if (bus.BUSY) busy_cycles++;
    end
    check("shr10_busy_cycles", 32'(busy_cycles), 32'd10);
    check("shr10_q", 32'(bus.Q), 32'h00);
    check("shr10_done", 32'(bus.DONE), 32'h1);

    // AMT=0 burst, START with LOAD
    op1(3'b011, 1'b0, 1'b0, 8'h5A);
    drive(3'b001, 1'b1, 4'd0, 1'b1, 1'b1, 8'h00); tick();
    check("amt0_done", 32'(bus.DONE), 32'h1);
    check("amt0_busy", 32'(bus.BUSY), 32'h0);
    check("amt0_q", 32'(bus.Q), 32'h5A);
    drive(3'b011, 1'b1, 4'd4, 1'b0, 1'b0, 8'h3C); tick();
    check("start_load_q", 32'(bus.Q), 32'h3C);
    check("start_load_busy", 32'(bus.BUSY), 32'h0);

    // Back-to-back: new START in the DONE cycle
    op1(3'b011, 1'b0, 1'b0, 8'h01);
    drive(3'b101, 1'b1, 4'd1, 1'b0, 1'b0, 8'h00); tick();
    drive(3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00); tick();
    check("b2b_first_done", 32'(bus.DONE), 32'h1);
    drive(3'b100, 1'b1, 4'd2, 1'b0, 1'b0, 8'h00); tick();
    check("b2b_second_busy", 32'(bus.BUSY), 32'h1);
    drive(3'b000, 1'b0, 4'd0, 1'b0, 1'b0, 8'h00); tick(); tick();
    check("b2b_second_q", 32'(bus.Q), 32'h80);

    // Reset mid-burst
    op1(3'b011, 1'b0, 1'b0, 8'h01);
    drive(3'b101, 1'b1, 4'd7, 1'b0, 1'b0, 8'h00); tick();
    bus.START = 1'b0;
    tick(); tick(); tick();
    check("midrst_pre_q", 32'(bus.Q), 32'h08);
    CLR = 1'b1; tick(); CLR = 1'b0;
    check("midrst_q", 32'(bus.Q), 32'h00);
    check("midrst_busy", 32'(bus.BUSY), 32'h0);
    tick();
    check("midrst_nodone", 32'(bus.DONE), 32'h0);
    op1(3'b011, 1'b0, 1'b0, 8'h96);
    check("midrst_load", 32'(bus.Q), 32'h96);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(3'($urandom_range(7)), 1'($urandom_range(3) == 0), 4'($urandom),
            1'($urandom), 1'($urandom), 8'($urandom));
      CLR = 1'($urandom_range(49) == 0);
      tick();
    end
    CLR = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
